alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be 32 or 64.
REQ-002 Parameter SHIFT_STEP, default 1, max bits shifted per cycle; SHALL be a power of two, 1..XLEN.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
alu_op  in  3  main-decoder class: 000 load/store, 001 branch, 010 R-type, 011 I-type arith
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B (register or immediate)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  ALU result
zero  out  1  result == 0
alu_ctrl  out  4  decoded ALU control code of held operation
illegal  out  1  held operation had no legal decode

Function
REQ-005 Decode codes SHALL be: add 0010, sub 0110, and 0000, or 0001, xor 0011, slt 0111, sltu 1011, sll 1000, srl 1001, sra 1010.
REQ-006 alu_op 000 SHALL decode add; 001 SHALL decode sub.
REQ-007 alu_op 010 by funct3: 000 add (funct7b5=0) / sub (1); 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl (0) / sra (1); 110 or; 111 and.
REQ-008 alu_op 011: as REQ-007 except funct3 000 SHALL always be add (funct7b5 ignored).
REQ-009 alu_op 1xx SHALL decode and (0000) with illegal=1; every legal decode SHALL set illegal=0.
REQ-010 Decode and operands SHALL be captured on the accept edge (in_valid && in_ready); held outputs SHALL not change until the result is consumed.
REQ-011 FSM states: IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 IDLE, accept of non-shift op (or shift with shamt 0) -> DONE, result computed on that edge.
REQ-013 IDLE, accept of shift with shamt>0 -> SHIFT; shamt = op_b[log2(XLEN)-1:0]; upper op_b bits ignored.
REQ-014 SHIFT: each cycle shift by min(SHIFT_STEP, remaining), decrement remaining; when remaining reaches 0 on an edge -> DONE.
REQ-015 Latency accept-edge to out_valid SHALL be 1 cycle for non-shift, 1+ceil(shamt/SHIFT_STEP) cycles for shift.
REQ-016 DONE with out_ready=1 -> IDLE on that edge; out_ready=0 holds DONE and all outputs stable.
REQ-017 Arithmetic SHALL be modulo 2^XLEN; slt signed, sltu unsigned, result 0 or 1 zero-extended; sra replicates op_a[XLEN-1].
REQ-018 zero SHALL be combinationally equal to (result == 0) in all states.
REQ-019 in_valid outside IDLE SHALL be ignored, with no capture.
REQ-020 Back-to-back: minimum spacing between accepts SHALL be 2 cycles (accept, DONE+consume, IDLE).

Reset
REQ-021 reset=1 at a rising edge SHALL force IDLE from any state, aborting any shift in progress, with no result delivered.
REQ-022 After reset: in_ready=1, out_valid=0, result=0, alu_ctrl=0000, illegal=0, remaining count=0.
REQ-023 reset SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-024 alu_op=010, funct3=000, funct7b5=1, op_a=5, op_b=7 -> one cycle later out_valid=1, result=0xFFFFFFFE, alu_ctrl=0110, zero=0.
REQ-025 alu_op=011, funct3=000, funct7b5=1, op_a=3, op_b=3 -> result=6, alu_ctrl=0010 (funct7b5 ignored).
REQ-026 SHIFT_STEP=1, sra, op_a=0x80000000, op_b=0x24 (shamt 4) -> out_valid 5 cycles after accept, result=0xF8000000, in_ready=0 throughout.
REQ-027 slt op_a=0xFFFFFFFF, op_b=1 -> result=1; sltu same operands -> result=0, zero=1.
REQ-028 Shift of shamt 31 in progress, reset asserted mid-SHIFT -> next cycle in_ready=1, out_valid=0, result=0; subsequent add 1+1 -> result=2.
REQ-029 alu_op=100 -> illegal=1, alu_ctrl=0000; out_ready held 0 for 3 cycles -> outputs stable, in_valid ignored; out_ready=1 -> IDLE next cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execution unit: decodes alu_op/funct3/funct7b5, executes one operation per request and
// holds the result until consumed. Shifts run iteratively, up to SHIFT_STEP bits per cycle.
module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = ShW + 1;
  localparam logic [CntW-1:0] StepC = CntW'(SHIFT_STEP);

  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlXor  = 4'b0011;
  localparam logic [3:0] CtrlSlt  = 4'b0111;
  localparam logic [3:0] CtrlSltu = 4'b1011;
  localparam logic [3:0] CtrlSll  = 4'b1000;
  localparam logic [3:0] CtrlSrl  = 4'b1001;
  localparam logic [3:0] CtrlSra  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            illegal_q, illegal_d;
  logic [CntW-1:0] rem_q, rem_d;

  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic            dec_shift;
  logic [CntW-1:0] shamt;
  logic [CntW-1:0] step;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] shifted;

  always_comb begin
    dec_ctrl    = CtrlAnd;
    dec_illegal = 1'b0;
    case (alu_op)
      3'b000: dec_ctrl = CtrlAdd;
      3'b001: dec_ctrl = CtrlSub;
      3'b010, 3'b011: begin
        case (funct3)
          // funct7b5 selects sub only for register-register ops
          3'b000:  dec_ctrl = (funct7b5 && (alu_op == 3'b010)) ? CtrlSub : CtrlAdd;
          3'b001:  dec_ctrl = CtrlSll;
          3'b010:  dec_ctrl = CtrlSlt;
          3'b011:  dec_ctrl = CtrlSltu;
          3'b100:  dec_ctrl = CtrlXor;
          3'b101:  dec_ctrl = funct7b5 ? CtrlSra : CtrlSrl;
          3'b110:  dec_ctrl = CtrlOr;
          default: dec_ctrl = CtrlAnd;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_shift = (dec_ctrl == CtrlSll) || (dec_ctrl == CtrlSrl) || (dec_ctrl == CtrlSra);
  assign shamt     = {1'b0, op_b[ShW-1:0]};

  always_comb begin
    alu_out = op_a & op_b;
    case (dec_ctrl)
      CtrlAdd:  alu_out = op_a + op_b;
      CtrlSub:  alu_out = op_a - op_b;
      CtrlOr:   alu_out = op_a | op_b;
      CtrlXor:  alu_out = op_a ^ op_b;
      CtrlSlt:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      CtrlSltu: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      // Shifts start from op_a and are stepped in StShift
      CtrlSll, CtrlSrl, CtrlSra: alu_out = op_a;
      default:  alu_out = op_a & op_b;
    endcase
  end

  assign step = (rem_q < StepC) ? rem_q : StepC;

  always_comb begin
    shifted = result_q;
    case (ctrl_q)
      CtrlSll: shifted = result_q << step;
      CtrlSrl: shifted = result_q >> step;
      default: shifted = $unsigned($signed(result_q) >>> step);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    rem_d     = rem_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          ctrl_d    = dec_ctrl;
          illegal_d = dec_illegal;
          result_d  = alu_out;
          if (dec_shift && (shamt != '0)) begin
            rem_d   = shamt;
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        result_d = shifted;
        rem_d    = rem_q - step;
        if (rem_q == step) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      ctrl_q    <= CtrlAnd;
      illegal_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      rem_q     <= rem_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign alu_ctrl  = ctrl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: instruction-level reference model checked every cycle,
// plus directed vectors with literal expected results, latencies and flags.
module tb_alu_exec_unit;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SHIFT_STEP = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_ctrl;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(
    .XLEN      (XLEN),
    .SHIFT_STEP(SHIFT_STEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction mnemonic level
  typedef enum {MAdd, MSub, MAnd, MOr, MXor, MSlt, MSltu, MSll, MSrl, MSra, MBad} mop_e;

  function automatic mop_e m_decode(input logic [2:0] aop, input logic [2:0] f3, input logic f7);
    if (aop == 3'd0) return MAdd;
    if (aop == 3'd1) return MSub;
    if (aop >= 3'd4) return MBad;
    case (f3)
      3'd0:    return (f7 && aop == 3'd2) ? MSub : MAdd;
      3'd1:    return MSll;
      3'd2:    return MSlt;
      3'd3:    return MSltu;
      3'd4:    return MXor;
      3'd5:    return f7 ? MSra : MSrl;
      3'd6:    return MOr;
      default: return MAnd;
    endcase
  endfunction

  function automatic logic [3:0] m_code(input mop_e op);
    case (op)
      MAdd:    return 4'b0010;
      MSub:    return 4'b0110;
      MOr:     return 4'b0001;
      MXor:    return 4'b0011;
      MSlt:    return 4'b0111;
      MSltu:   return 4'b1011;
      MSll:    return 4'b1000;
      MSrl:    return 4'b1001;
      MSra:    return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_exec(input mop_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      MAdd:    return a + b;
      MSub:    return a - b;
      MOr:     return a | b;
      MXor:    return a ^ b;
      MSlt:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      MSltu:   return (a < b) ? 32'd1 : 32'd0;
      MSll:    return a << b[4:0];
      MSrl:    return a >> b[4:0];
      MSra:    return $unsigned($signed(a) >>> b[4:0]);
      default: return a & b;
    endcase
  endfunction

  // Model state: 0 idle, 1 computing shift, 2 result held
  int          m_state = 0;
  int          m_wait  = 0;
  bit          m_init  = 1'b0;
  bit          m_rst   = 1'b0;
  logic [31:0] m_res   = '0;
  logic [3:0]  m_ctrl  = '0;
  logic        m_ill   = 1'b0;

  initial begin
    mop_e op;
    int   sh;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_state = 0;
        m_res   = '0;
        m_ctrl  = '0;
        m_ill   = 1'b0;
        m_rst   = 1'b1;
        m_init  = 1'b1;
      end else if (m_init) begin
        case (m_state)
          0: if (in_valid) begin
            op     = m_decode(alu_op, funct3, funct7b5);
            m_res  = m_exec(op, op_a, op_b);
            m_ctrl = m_code(op);
            m_ill  = (op == MBad);
            m_rst  = 1'b0;
            sh     = int'(op_b[4:0]);
            if ((op == MSll || op == MSrl || op == MSra) && sh > 0) begin
              m_wait  = (sh + SHIFT_STEP - 1) / SHIFT_STEP;
              m_state = 1;
            end else begin
              m_state = 2;
            end
          end
          1: begin
            m_wait--;
            if (m_wait == 0) m_state = 2;
          end
          default: if (out_ready) m_state = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("in_ready", 64'(in_ready), 64'(m_state == 0));
        chk("out_valid", 64'(out_valid), 64'(m_state == 2));
        if (m_state == 2 || (m_state == 0 && m_rst)) begin
          chk("model result", 64'(result), 64'(m_res));
          chk("model alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
          chk("model illegal", 64'(illegal), 64'(m_ill));
          chk("model zero", 64'(zero), 64'(m_res == 0));
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] aop, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ec, input logic ei,
                        input int el, input int hold);
    int lat;
    alu_op   = aop;
    funct3   = f3;
    funct7b5 = f7;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Keep requesting with altered operands; must be ignored while busy
    op_a = ~a;
    lat  = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(el));
    chk({name, " result"}, 64'(result), 64'(er));
    chk({name, " alu_ctrl"}, 64'(alu_ctrl), 64'(ec));
    chk({name, " illegal"}, 64'(illegal), 64'(ei));
    chk({name, " zero"}, 64'(zero), 64'(er == 0));
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({name, " held result"}, 64'(result), 64'(er));
      chk({name, " held out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({name, " back to idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = '0;
    funct3    = '0;
    funct7b5  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);

    run_op("sub",    3'b010, 3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1'b0, 1, 0);
    run_op("addi",   3'b011, 3'b000, 1'b1, 32'd3, 32'd3, 32'd6, 4'b0010, 1'b0, 1, 0);
    run_op("sra4",   3'b010, 3'b101, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'b1010, 1'b0,
           5, 0);
    run_op("slt",    3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1'b0, 1, 0);
    run_op("sltu",   3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1011, 1'b0, 1, 0);
    run_op("illeg",  3'b100, 3'b000, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000, 1'b1, 1, 3);
    run_op("ldst",   3'b000, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0010, 1'b0, 1, 0);
    run_op("branch", 3'b001, 3'b101, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0110, 1'b0, 1, 1);
    run_op("slli3",  3'b011, 3'b001, 1'b0, 32'd1, 32'hFFFF_FFE3, 32'd8, 4'b1000, 1'b0, 4, 0);
    run_op("srl0",   3'b010, 3'b101, 1'b0, 32'h1234, 32'h20, 32'h1234, 4'b1001, 1'b0, 1, 0);
    run_op("or",     3'b010, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'hFF, 4'b0001, 1'b0, 1, 0);
    run_op("and",    3'b010, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'h30, 4'b0000, 1'b0, 1, 0);
    run_op("xor",    3'b010, 3'b100, 1'b0, 32'hFF, 32'h0F, 32'hF0, 4'b0011, 1'b0, 1, 0);
    run_op("srai2",  3'b011, 3'b101, 1'b1, 32'h4000_0000, 32'h402, 32'h1000_0000, 4'b1010, 1'b0,
           3, 0);
    run_op("srl31",  3'b010, 3'b101, 1'b0, 32'h8000_0000, 32'd31, 32'd1, 4'b1001, 1'b0, 32, 0);

    // Abort a 31-bit shift mid-way; reset wins over in_valid/out_ready on the same edge
    alu_op   = 3'b010;
    funct3   = 3'b001;
    funct7b5 = 1'b0;
    op_a     = 32'd1;
    op_b     = 32'd31;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-shift busy", 64'(in_ready), 64'd0);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort alu_ctrl", 64'(alu_ctrl), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort no result", 64'(out_valid), 64'd0);
    run_op("add1+1", 3'b010, 3'b000, 1'b0, 32'd1, 32'd1, 32'd2, 4'b0010, 1'b0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
